// File: rtl/stopwatch_sec_counter.sv
// stopwatch_sec_counter: debounced start/stop + clear buttons driving a
// 0..CNT_MAX seconds counter. It increments once every TICK_DIV clocks
// while running, and its carry pulse feeds the minutes stage.
module stopwatch_sec_counter #(
  parameter int unsigned TICK_DIV     = 50_000_000,
  parameter int unsigned DEBOUNCE_CYC = 1_000_000,
  parameter int unsigned CNT_MAX      = 59
) (
  input  logic       clock,
  input  logic       rst,
  input  logic       btn_ss,
  input  logic       btn_clr,
  output logic [5:0] hex,
  output logic       carry,
  output logic       run
);

  localparam int unsigned PRE_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int unsigned DB_W  = $clog2(DEBOUNCE_CYC + 1);

  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(TICK_DIV - 1);
  localparam logic [DB_W-1:0]  DB_LAST  = DB_W'(DEBOUNCE_CYC - 1);
  localparam logic [5:0]       HEX_MAX  = 6'(CNT_MAX);

  // Button lanes: bit 0 is start/stop, bit 1 is clear.
  localparam int BTN_SS  = 0;
  localparam int BTN_CLR = 1;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_PAUSE = 2'd2;

  // Next count and wrap flag for one increment; wrap also covers any
  // out-of-range value so the counter can never stick above CNT_MAX.
  function automatic logic [6:0] count_step(input logic [5:0] cur);
    if (cur >= HEX_MAX) begin
      count_step = {1'b1, 6'd0};
    end else begin
      count_step = {1'b0, cur + 6'd1};
    end
  endfunction

  logic [1:0] btn_raw;
  assign btn_raw = {btn_clr, btn_ss};

  // ---------------------------------------------------------------------
  // Stage: two-flop synchronizers for the asynchronous buttons
  // ---------------------------------------------------------------------
  logic [1:0] meta_q;
  logic [1:0] sync_q;

  // Bring both raw buttons into the clock domain.
  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      meta_q <= 2'b00;
      sync_q <= 2'b00;
    end else begin
      meta_q <= btn_raw;
      sync_q <= meta_q;
    end
  end

  // ---------------------------------------------------------------------
  // Stage: debouncers (level accepted after DEBOUNCE_CYC stable cycles)
  // ---------------------------------------------------------------------
  logic [1:0]      level_q;
  logic [1:0]      level_d;
  logic [DB_W-1:0] db_cnt_q [2];
  logic [DB_W-1:0] db_cnt_d [2];

  // Count cycles of disagreement; the cycle that would reach
  // DEBOUNCE_CYC instead adopts the new level and restarts the count.
  always_comb begin
    for (int i = 0; i < 2; i++) begin
      level_d[i]  = level_q[i];
      db_cnt_d[i] = '0;
      if (sync_q[i] != level_q[i]) begin
        if (db_cnt_q[i] == DB_LAST) begin
          level_d[i] = sync_q[i];
        end else begin
          db_cnt_d[i] = db_cnt_q[i] + DB_W'(1);
        end
      end
    end
  end

  // Debounce state registers.
  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      level_q <= 2'b00;
      for (int i = 0; i < 2; i++) begin
        db_cnt_q[i] <= '0;
      end
    end else begin
      level_q <= level_d;
      for (int i = 0; i < 2; i++) begin
        db_cnt_q[i] <= db_cnt_d[i];
      end
    end
  end

  // ---------------------------------------------------------------------
  // Stage: rising-edge detection -> one-cycle commands
  // ---------------------------------------------------------------------
  logic [1:0] prev_q;
  logic       ss_p;
  logic       clr_p;

  // Delayed copy of the debounced levels; releases produce no command.
  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      prev_q <= 2'b00;
    end else begin
      prev_q <= level_q;
    end
  end

  assign ss_p  = level_q[BTN_SS]  & ~prev_q[BTN_SS];
  assign clr_p = level_q[BTN_CLR] & ~prev_q[BTN_CLR];

  // ---------------------------------------------------------------------
  // Stage: control FSM, prescaler and seconds counter
  // ---------------------------------------------------------------------
  logic [1:0]       state_q;
  logic [1:0]       state_d;
  logic [PRE_W-1:0] pre_q;
  logic [PRE_W-1:0] pre_d;
  logic [5:0]       hex_q;
  logic [5:0]       hex_d;
  logic             carry_q;
  logic             carry_d;
  logic             tick;
  logic [6:0]       step_res;

  // Start/stop toggles between RUN and PAUSE; clear overrides everything.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (ss_p) state_d = S_RUN;
      S_RUN:   if (ss_p) state_d = S_PAUSE;
      S_PAUSE: if (ss_p) state_d = S_RUN;
      default: state_d = S_IDLE;
    endcase
    if (clr_p) begin
      state_d = S_IDLE;
    end
  end

  assign tick     = (state_q == S_RUN) && (pre_q == PRE_LAST);
  assign step_res = count_step(hex_q);

  // Prescaler runs only in RUN, holds in PAUSE so a resumed second
  // finishes its remaining cycles, and sits at zero in IDLE.
  always_comb begin
    pre_d = pre_q;
    if (clr_p || (state_q == S_IDLE)) begin
      pre_d = '0;
    end else if (state_q == S_RUN) begin
      pre_d = tick ? '0 : pre_q + PRE_W'(1);
    end
  end

  // Seconds count and wrap carry; clear zeroes the count without a carry.
  always_comb begin
    hex_d   = hex_q;
    carry_d = 1'b0;
    if (clr_p) begin
      hex_d = 6'd0;
    end else if (tick) begin
      hex_d   = step_res[5:0];
      carry_d = step_res[6];
    end
  end

  // Control and count registers.
  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      pre_q   <= '0;
      hex_q   <= 6'd0;
      carry_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pre_q   <= pre_d;
      hex_q   <= hex_d;
      carry_q <= carry_d;
    end
  end

  assign hex   = hex_q;
  assign carry = carry_q;
  assign run   = (state_q == S_RUN);

endmodule

// File: tb/tb_stopwatch_sec_counter.sv
// Directed bench for stopwatch_sec_counter with TICK_DIV=4,
// DEBOUNCE_CYC=3, CNT_MAX=59. Inputs change 1 time unit after a rising
// edge; outputs are checked at that same point.
module tb_stopwatch_sec_counter;

  logic       clock;
  logic       rst;
  logic       btn_ss;
  logic       btn_clr;
  logic [5:0] hex;
  logic       carry;
  logic       run;

  int checks   = 0;
  int failures = 0;

  stopwatch_sec_counter #(
    .TICK_DIV     (4),
    .DEBOUNCE_CYC (3),
    .CNT_MAX      (59)
  ) dut (
    .clock   (clock),
    .rst     (rst),
    .btn_ss  (btn_ss),
    .btn_clr (btn_clr),
    .hex     (hex),
    .carry   (carry),
    .run     (run)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Advance n rising edges, landing 1 time unit after the last one.
  task automatic step(input int n);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  initial begin
    rst     = 1'b1;
    btn_ss  = 1'b0;
    btn_clr = 1'b0;

    // Reset state
    step(2);
    check("rst_hex",   32'(hex),   32'd0);
    check("rst_run",   32'(run),   32'd0);
    check("rst_carry", 32'(carry), 32'd0);
    rst = 1'b0;
    step(3);

    // Hold start/stop from edge k: RUN after k+5, hex=1 after k+9
    btn_ss = 1'b1;
    step(5);
    check("start_k4_run",  32'(run), 32'd0);
    step(1);
    check("start_k5_run",  32'(run), 32'd1);
    check("start_k5_hex",  32'(hex), 32'd0);
    step(3);
    check("start_k8_hex",  32'(hex), 32'd0);
    step(1);
    check("start_k9_hex",  32'(hex), 32'd1);
    step(4);
    check("start_k13_hex", 32'(hex), 32'd2);
    btn_ss = 1'b0;

    // Run up to 17 and reset asynchronously between edges
    step(60);
    check("pre_reset_hex", 32'(hex), 32'd17);
    check("pre_reset_run", 32'(run), 32'd1);
    #2;
    rst = 1'b1;
    #1;
    check("async_rst_hex",   32'(hex),   32'd0);
    check("async_rst_run",   32'(run),   32'd0);
    check("async_rst_carry", 32'(carry), 32'd0);
    step(1);
    rst = 1'b0;
    step(20);
    check("post_rst_hex", 32'(hex), 32'd0);
    check("post_rst_run", 32'(run), 32'd0);

    // Start again and run through the 59 -> 0 wrap
    btn_ss = 1'b1;
    step(6);
    check("wrap_start_run", 32'(run), 32'd1);
    btn_ss = 1'b0;
    step(236);
    check("wrap_hex59",     32'(hex),   32'd59);
    check("wrap_carry_pre", 32'(carry), 32'd0);
    step(3);
    check("wrap_hex59_last", 32'(hex),   32'd59);
    check("wrap_carry_last", 32'(carry), 32'd0);
    step(1);
    check("wrap_hex0",   32'(hex),   32'd0);
    check("wrap_carry1", 32'(carry), 32'd1);
    step(1);
    check("wrap_hex0_next",   32'(hex),   32'd0);
    check("wrap_carry_after", 32'(carry), 32'd0);

    // Pause with prescaler=2 and hex=5, then resume
    step(15);
    check("pause_pre_hex4", 32'(hex), 32'd4);
    btn_ss = 1'b1;
    step(5);
    check("pause_before_run", 32'(run), 32'd1);
    check("pause_before_hex", 32'(hex), 32'd5);
    step(1);
    check("pause_run", 32'(run), 32'd0);
    check("pause_hex", 32'(hex), 32'd5);
    btn_ss = 1'b0;
    step(20);
    check("paused_hex", 32'(hex), 32'd5);
    check("paused_run", 32'(run), 32'd0);
    btn_ss = 1'b1;
    step(6);
    check("resume_run",    32'(run), 32'd1);
    check("resume_r0_hex", 32'(hex), 32'd5);
    step(1);
    check("resume_r1_hex", 32'(hex), 32'd5);
    step(1);
    check("resume_r2_hex", 32'(hex), 32'd6);
    btn_ss = 1'b0;
    step(10);

    // Bounce shorter than the debounce window: no pause
    btn_ss = 1'b1;
    step(2);
    btn_ss = 1'b0;
    step(1);
    btn_ss = 1'b1;
    step(2);
    btn_ss = 1'b0;
    step(10);
    check("bounce_run", 32'(run), 32'd1);
    check("bounce_hex", 32'(hex), 32'd12);

    // Clear and start/stop together at hex=30: clear wins
    step(67);
    check("clr_pre_hex29", 32'(hex), 32'd29);
    btn_ss  = 1'b1;
    btn_clr = 1'b1;
    step(4);
    check("clr_pre_hex30", 32'(hex), 32'd30);
    step(1);
    check("clr_last_run", 32'(run), 32'd1);
    check("clr_last_hex", 32'(hex), 32'd30);
    step(1);
    check("clr_hex",   32'(hex),   32'd0);
    check("clr_run",   32'(run),   32'd0);
    check("clr_carry", 32'(carry), 32'd0);
    step(1);
    check("clr_next_carry", 32'(carry), 32'd0);
    check("clr_next_hex",   32'(hex),   32'd0);
    btn_ss  = 1'b0;
    btn_clr = 1'b0;
    step(20);
    check("clr_idle_run", 32'(run), 32'd0);
    check("clr_idle_hex", 32'(hex), 32'd0);

    // Hold start/stop for 100 cycles: one command only
    btn_ss = 1'b1;
    step(5);
    check("hold_k4_run", 32'(run), 32'd0);
    step(1);
    check("hold_k5_run", 32'(run), 32'd1);
    step(95);
    check("hold_end_run", 32'(run), 32'd1);
    check("hold_end_hex", 32'(hex), 32'd23);
    btn_ss = 1'b0;
    step(10);
    btn_ss = 1'b1;
    step(5);
    check("repress_k4_run", 32'(run), 32'd1);
    step(1);
    check("repress_k5_run", 32'(run), 32'd0);
    check("repress_hex",    32'(hex), 32'd27);
    btn_ss = 1'b0;
    step(5);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
